up_down_counter: RTL and testbench

//   Synchronous n-bit binary up/down counter with count enable and async active-low clear.

---
 rtl/up_down_counter_if.sv | 33 +++
 rtl/up_down_counter.sv | 31 +++
 tb/tb_up_down_counter.sv | 115 +++++++++++
 3 files changed

// File: rtl/up_down_counter_if.sv
// Control/status bundle for up_down_counter.
// The counter drives Q, and drives tc when UP_DOWN_COUNTER_TC_EN is defined.
// The user side drives the direction (up) and the count enable.
interface up_down_counter_if #(
    parameter int n = 4
);
    logic         up;
    logic         enable;
    logic [n-1:0] Q;
`ifdef UP_DOWN_COUNTER_TC_EN
    logic         tc;
`endif

    // User side: issues count requests and observes the count.
    modport master (
        output up,
        output enable,
`ifdef UP_DOWN_COUNTER_TC_EN
        input  tc,
`endif
        input  Q
    );

    // Counter side.
    modport slave (
        input  up,
        input  enable,
`ifdef UP_DOWN_COUNTER_TC_EN
        output tc,
`endif
        output Q
    );
endinterface

// File: rtl/up_down_counter.sv
// n-bit binary up/down counter with count enable and asynchronous active-low clear.
// Optional feature macro: UP_DOWN_COUNTER_TC_EN adds the combinational terminal-count
// output tc. tc is high when the next enabled edge wraps the count.
// Wrap-around is modular in both directions; nothing saturates and no error is flagged.
module up_down_counter #(
    parameter int n = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    up_down_counter_if.slave  bus
);

    logic [n-1:0] cnt;

    // Count register: async clear, then hold or step by one in the requested direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (bus.enable)
            cnt <= bus.up ? cnt + 1'b1 : cnt - 1'b1;
    end

    assign bus.Q = cnt;

`ifdef UP_DOWN_COUNTER_TC_EN
    // Terminal count: the next edge wraps. Forced low while reset is held.
    assign bus.tc = reset_n & bus.enable &
                    ((bus.up & (cnt == {n{1'b1}})) | (~bus.up & (cnt == '0)));
`endif

endmodule

// File: tb/tb_up_down_counter.sv
// Scoreboard bench for up_down_counter (n=4, 4 ns clock).
// The driver applies one directed vector per cycle, #1 after the rising edge, and
// queues the hand-computed count (and tc when UP_DOWN_COUNTER_TC_EN is defined)
// expected during that cycle. The monitor pops and compares on each falling edge.
`timescale 1ns/100ps
module tb_up_down_counter;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       up;
        logic [3:0] q;
        logic       tc;
    } vec_t;

    logic clk;
    logic reset_n;

    up_down_counter_if #(.n(4)) bus ();

    up_down_counter #(.n(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t stim_q[$];
    vec_t exp_q[$];

    initial clk = 1'b0;
    always #2 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic u,
                       input logic [3:0] q, input logic t);
        vec_t v;
        v.rst_n = r; v.en = e; v.up = u; v.q = q; v.tc = t;
        stim_q.push_back(v);
    endtask

    // Monitor: compare the cycle's observed count against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            check("Q", bus.Q, e.q);
`ifdef UP_DOWN_COUNTER_TC_EN
            check("tc", {3'b000, bus.tc}, {3'b000, e.tc});
`endif
        end
    end

    // Driver: directed trace, one vector per cycle.
    initial begin
        reset_n    = 1'b0;
        bus.enable = 1'b0;
        bus.up     = 1'b1;
        #1 reset_n = 1'b1;
        #0.5 check("Q_after_reset", bus.Q, 4'd0);

        // rst_n, en, up, Q during the cycle, tc during the cycle
        add(1,0,1, 0,0);                                      // held at 0 until enabled
        add(1,1,1, 0,0); add(1,1,1, 1,0); add(1,1,1, 2,0); add(1,1,1, 3,0);
        add(1,1,1, 4,0); add(1,1,1, 5,0); add(1,1,1, 6,0); add(1,1,1, 7,0);
        add(1,1,1, 8,0); add(1,1,1, 9,0); add(1,1,1,10,0); add(1,1,1,11,0);
        add(1,1,1,12,0); add(1,1,1,13,0); add(1,1,1,14,0); add(1,1,1,15,1); // up wrap
        add(1,1,0, 0,1);                                      // down wrap from 0
        add(1,1,0,15,0); add(1,1,0,14,0); add(1,1,0,13,0); add(1,1,0,12,0);
        add(1,1,0,11,0); add(1,1,0,10,0); add(1,1,0, 9,0); add(1,1,0, 8,0);
        add(1,1,0, 7,0); add(1,1,0, 6,0);
        add(1,0,0, 5,0); add(1,0,1, 5,0); add(1,0,0, 5,0);    // hold, up toggling
        add(1,0,1, 5,0); add(1,0,0, 5,0);
        add(1,1,1, 5,0); add(1,1,1, 6,0);
        add(1,0,1, 7,0);                                      // sitting at 7
        add(0,1,1, 0,0);                                      // async clear mid-cycle
        add(0,1,1, 0,0);                                      // edge during reset ignored
        add(1,1,1, 0,0);                                      // release
        add(1,1,1, 1,0); add(1,1,1, 2,0); add(1,1,1, 3,0);
        add(1,1,0, 4,0);                                      // direction flip at 4
        add(1,1,0, 3,0);
        add(1,0,0, 2,0);

        while (stim_q.size() > 0) begin
            vec_t v;
            v = stim_q.pop_front();
            @(posedge clk);
            #1;
            reset_n    = v.rst_n;
            bus.enable = v.en;
            bus.up     = v.up;
            exp_q.push_back(v);
        end

        // Let the monitor drain, with a bounded wait.
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
